// File: rtl/id_stage_pipelined_if.sv
// IF->ID->EX handshake bundle plus the WB write port.
// The slave modport is the decode stage's view of the bundle.
interface id_stage_pipelined_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              InValid;
   logic              InReady;
   logic [31:0]       Instruction;
   logic              Flush;
   logic              WriteRegSignal;
   logic [REG_AW-1:0] Rwrite;
   logic [DATA_W-1:0] WriteData;
   logic              OutValid;
   logic              OutReady;
   logic [5:0]        OutOpcode;
   logic [REG_AW-1:0] Rdestination;
   logic [REG_AW-1:0] Rprimary_base;
   logic [REG_AW-1:0] Rsecondary_store;
   logic [DATA_W-1:0] ReadPrimary;
   logic [DATA_W-1:0] ReadSecondary;

   modport slave (
      input  InValid, Instruction, Flush,
      input  WriteRegSignal, Rwrite, WriteData,
      input  OutReady,
      output InReady, OutValid, OutOpcode,
      output Rdestination, Rprimary_base, Rsecondary_store,
      output ReadPrimary, ReadSecondary
   );

   modport master (
      output InValid, Instruction, Flush,
      output WriteRegSignal, Rwrite, WriteData,
      output OutReady,
      input  InReady, OutValid, OutOpcode,
      input  Rdestination, Rprimary_base, Rsecondary_store,
      input  ReadPrimary, ReadSecondary
   );
endinterface

// File: rtl/id_stage_pipelined.sv
// Decode stage: 2R/1W register bank with WB bypass,
// load-use stall, flush and a single ID/EX holding register.
module id_stage_pipelined #(
   parameter int         DATA_W   = 32,
   parameter int         REG_AW   = 4,
   parameter bit         ZERO_REG = 1'b1,
   parameter logic [5:0] LOAD_OP  = 6'h23
) (
   input logic ClockInput,
   input logic ResetInputN,
   id_stage_pipelined_if.slave bus
);
   localparam int NREG = 1 << REG_AW;

   typedef struct packed {
      logic [5:0]        op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } id_ex_t;

   id_ex_t            q;
   id_ex_t            d_in;
   logic              valid_q;
   logic [DATA_W-1:0] bank [NREG];

   logic [5:0]        dec_op;
   logic [REG_AW-1:0] dec_rd;
   logic [REG_AW-1:0] dec_rs1;
   logic [REG_AW-1:0] dec_rs2;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic              wr_en;
   logic              hazard;
   logic              in_ready;
   logic              accept;
   logic              unused_instr;

   assign dec_op  = bus.Instruction[31:26];
   assign dec_rd  = bus.Instruction[25 -: REG_AW];
   assign dec_rs1 = bus.Instruction[25-REG_AW -: REG_AW];
   assign dec_rs2 = bus.Instruction[25-2*REG_AW -: REG_AW];
   assign unused_instr = ^bus.Instruction[25-3*REG_AW:0];

   function automatic logic is_zero(input logic [REG_AW-1:0] r);
      return ZERO_REG && (r == '0);
   endfunction

   assign wr_en = bus.WriteRegSignal && !is_zero(bus.Rwrite);

   // Write-first read: a same-cycle WB write wins over the bank.
   always_comb begin
      opa = bank[dec_rs1];
      if (is_zero(dec_rs1))
         opa = '0;
      else if (wr_en && bus.Rwrite == dec_rs1)
         opa = bus.WriteData;
   end

   always_comb begin
      opb = bank[dec_rs2];
      if (is_zero(dec_rs2))
         opb = '0;
      else if (wr_en && bus.Rwrite == dec_rs2)
         opb = bus.WriteData;
   end

   assign d_in = '{op: dec_op, rd: dec_rd, rs1: dec_rs1,
                   rs2: dec_rs2, a: opa, b: opb};

   assign hazard = bus.InValid && valid_q
                && (q.op == LOAD_OP) && !is_zero(q.rd)
                && (q.rd == dec_rs1 || q.rd == dec_rs2);

   assign in_ready = (!valid_q || bus.OutReady) && !hazard;
   assign accept   = bus.InValid && in_ready && !bus.Flush;

   always_ff @(posedge ClockInput or negedge ResetInputN) begin
      if (!ResetInputN) begin
         for (int i = 0; i < NREG; i++)
            bank[i] <= '0;
      end else if (wr_en) begin
         bank[bus.Rwrite] <= bus.WriteData;
      end
   end

   always_ff @(posedge ClockInput or negedge ResetInputN) begin
      if (!ResetInputN) begin
         valid_q <= 1'b0;
         q       <= '0;
      end else if (bus.Flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         q       <= d_in;
      end else if (valid_q && bus.OutReady) begin
         valid_q <= 1'b0;
      end else if (valid_q) begin
         // Stalled: keep held operands coherent with late WB writes.
         if (wr_en && bus.Rwrite == q.rs1)
            q.a <= bus.WriteData;
         if (wr_en && bus.Rwrite == q.rs2)
            q.b <= bus.WriteData;
      end
   end

   assign bus.InReady          = in_ready;
   assign bus.OutValid         = valid_q;
   assign bus.OutOpcode        = q.op;
   assign bus.Rdestination     = q.rd;
   assign bus.Rprimary_base    = q.rs1;
   assign bus.Rsecondary_store = q.rs2;
   assign bus.ReadPrimary      = q.a;
   assign bus.ReadSecondary    = q.b;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: reset, bypass,
// load-use bubble, stall refresh, flush and register-0 handling.
module tb_id_stage_pipelined;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   id_stage_pipelined_if #(.DATA_W(32), .REG_AW(4)) bus ();

   id_stage_pipelined #(
      .DATA_W(32), .REG_AW(4), .ZERO_REG(1'b1), .LOAD_OP(6'h23)
   ) dut (
      .ClockInput (clk),
      .ResetInputN(rst_n),
      .bus        (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mk(input logic [5:0] op,
                                      input logic [3:0] rd,
                                      input logic [3:0] rs1,
                                      input logic [3:0] rs2);
      return {op, rd, rs1, rs2, 14'h0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.InValid        = 1'b0;
      bus.Instruction    = '0;
      bus.Flush          = 1'b0;
      bus.WriteRegSignal = 1'b0;
      bus.Rwrite         = '0;
      bus.WriteData      = '0;
      bus.OutReady       = 1'b0;
      #3;
      check("rst_valid", 32'(bus.OutValid), 32'h0);
      check("rst_rp", bus.ReadPrimary, 32'h0);
      check("rst_ready", 32'(bus.InReady), 32'h1);
      tick();
      rst_n = 1'b1;

      // T1: write R3, hold an instruction, then async reset
      bus.WriteRegSignal = 1'b1;
      bus.Rwrite = 4'd3;
      bus.WriteData = 32'hA5;
      bus.InValid = 1'b1;
      bus.Instruction = mk(6'h00, 4'd1, 4'd3, 4'd0);
      tick();
      check("t1_valid", 32'(bus.OutValid), 32'h1);
      check("t1_byp", bus.ReadPrimary, 32'hA5);
      bus.WriteRegSignal = 1'b0;
      bus.InValid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t1_async_valid", 32'(bus.OutValid), 32'h0);
      check("t1_async_rp", bus.ReadPrimary, 32'h0);
      tick();
      rst_n = 1'b1;
      bus.InValid = 1'b1;
      bus.Instruction = mk(6'h00, 4'd1, 4'd3, 4'd0);
      tick();
      check("t1_r3_clear", bus.ReadPrimary, 32'h0);
      bus.InValid = 1'b0;
      bus.OutReady = 1'b1;
      tick();
      check("t1_drain", 32'(bus.OutValid), 32'h0);

      // T2: WB bypass into Rs1
      bus.WriteRegSignal = 1'b1;
      bus.Rwrite = 4'd5;
      bus.WriteData = 32'h1234;
      bus.InValid = 1'b1;
      bus.Instruction = mk(6'h01, 4'd2, 4'd5, 4'd3);
      tick();
      check("t2_rp", bus.ReadPrimary, 32'h1234);
      check("t2_rs", bus.ReadSecondary, 32'h0);
      check("t2_rd", 32'(bus.Rdestination), 32'd2);
      check("t2_op", 32'(bus.OutOpcode), 32'h01);
      bus.WriteRegSignal = 1'b0;
      bus.InValid = 1'b0;
      tick();

      // T3: load-use bubble
      bus.InValid = 1'b1;
      bus.Instruction = mk(6'h23, 4'd7, 4'd0, 4'd0);
      tick();
      check("t3_ld_valid", 32'(bus.OutValid), 32'h1);
      check("t3_ld_op", 32'(bus.OutOpcode), 32'h23);
      bus.Instruction = mk(6'h02, 4'd8, 4'd1, 4'd7);
      #1;
      check("t3_stall", 32'(bus.InReady), 32'h0);
      tick();
      check("t3_bubble", 32'(bus.OutValid), 32'h0);
      check("t3_ready", 32'(bus.InReady), 32'h1);
      tick();
      check("t3_dep_valid", 32'(bus.OutValid), 32'h1);
      check("t3_dep_rd", 32'(bus.Rdestination), 32'd8);
      check("t3_dep_rs2", 32'(bus.Rsecondary_store), 32'd7);
      bus.InValid = 1'b0;
      tick();

      // T4: stall refresh of held Rs1
      bus.WriteRegSignal = 1'b1;
      bus.Rwrite = 4'd4;
      bus.WriteData = 32'h55;
      bus.InValid = 1'b1;
      bus.OutReady = 1'b0;
      bus.Instruction = mk(6'h03, 4'd9, 4'd2, 4'd4);
      tick();
      check("t4_pre_rp", bus.ReadPrimary, 32'h0);
      check("t4_pre_rs", bus.ReadSecondary, 32'h55);
      bus.InValid = 1'b0;
      bus.Rwrite = 4'd2;
      bus.WriteData = 32'hDEAD;
      tick();
      check("t4_ref_rp", bus.ReadPrimary, 32'hDEAD);
      check("t4_ref_rs", bus.ReadSecondary, 32'h55);
      check("t4_ref_rd", 32'(bus.Rdestination), 32'd9);
      check("t4_ref_op", 32'(bus.OutOpcode), 32'h03);
      check("t4_ref_valid", 32'(bus.OutValid), 32'h1);
      bus.WriteRegSignal = 1'b0;
      tick();
      check("t4_hold_rp", bus.ReadPrimary, 32'hDEAD);

      // T5: flush drops held and refuses input
      bus.InValid = 1'b1;
      bus.Instruction = mk(6'h04, 4'd10, 4'd4, 4'd4);
      bus.OutReady = 1'b1;
      bus.Flush = 1'b1;
      #1;
      check("t5_inready", 32'(bus.InReady), 32'h1);
      tick();
      check("t5_valid", 32'(bus.OutValid), 32'h0);
      check("t5_not_taken", 32'(bus.Rdestination), 32'd9);
      bus.Flush = 1'b0;
      tick();
      check("t5_retake", 32'(bus.Rdestination), 32'd10);
      check("t5_rp", bus.ReadPrimary, 32'h55);

      // T6: register 0 ignores writes and never causes a stall
      bus.WriteRegSignal = 1'b1;
      bus.Rwrite = 4'd0;
      bus.WriteData = 32'hFFFF;
      bus.Instruction = mk(6'h05, 4'd11, 4'd0, 4'd4);
      tick();
      check("t6_byp_r0", bus.ReadPrimary, 32'h0);
      bus.WriteRegSignal = 1'b0;
      bus.Instruction = mk(6'h23, 4'd0, 4'd0, 4'd0);
      tick();
      check("t6_ld_op", 32'(bus.OutOpcode), 32'h23);
      bus.Instruction = mk(6'h06, 4'd12, 4'd0, 4'd0);
      #1;
      check("t6_no_stall", 32'(bus.InReady), 32'h1);
      tick();
      check("t6_take_rd", 32'(bus.Rdestination), 32'd12);
      check("t6_bank_r0", bus.ReadPrimary, 32'h0);
      bus.InValid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
